// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame-buffer geometry, write-port types and arbiter states
package frame_pkg;

    localparam int COLS_DEF = 40;
    localparam int ROWS_DEF = 30;

    typedef logic [5:0] coord_t;
    typedef logic [4:0] char_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        char_t  char;
    } frame_wr_t;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting after the last winner
module rr_arbiter #(
    parameter  int NREQ = 3,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    // Walk offsets from farthest to nearest so the nearest valid requester overwrites the rest.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(last) + off) % NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_write_arbiter.sv
// rtl/frame_write_arbiter.sv - round-robin frame-buffer write arbiter with full-screen clear sequencer
module frame_write_arbiter
    import frame_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [6*NREQ-1:0] req_x,
    input  logic [6*NREQ-1:0] req_y,
    input  logic [5*NREQ-1:0] req_char,
    output logic [5:0]        x,
    output logic [5:0]        y,
    output logic [4:0]        char,
    output logic              we,
    output logic              busy,
    output logic              drop_err
);

    localparam int     IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam coord_t XMAX = coord_t'(COLS - 1);
    localparam coord_t YMAX = coord_t'(ROWS - 1);

    arb_state_e state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    coord_t        cx_q, cx_d, cy_q, cy_d;
    frame_wr_t     wr_q, wr_d;
    logic          we_q, we_d;
    logic          drop_q, drop_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] ready_c;
    coord_t          gx, gy;
    char_t           gc;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign gx = req_x[6*int'(grant_idx) +: 6];
    assign gy = req_y[6*int'(grant_idx) +: 6];
    assign gc = req_char[5*int'(grant_idx) +: 5];

    // cx/cy hold the cell most recently written by the clear, so the first cell is
    // issued from ARB and the final cycle in CLEAR only has to notice completion.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        wr_d    = wr_q;
        we_d    = 1'b0;
        drop_d  = drop_q;
        ready_c = '0;
        unique case (state_q)
            ST_ARB: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                    wr_d    = '{x: '0, y: '0, char: '0};
                    we_d    = 1'b1;
                end else if (grant_any) begin
                    ready_c = grant;
                    last_d  = grant_idx;
                    if (gx <= XMAX && gy <= YMAX) begin
                        wr_d = '{x: gx, y: gy, char: gc};
                        we_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (cx_q == XMAX && cy_q == YMAX) begin
                    state_d = ST_ARB;
                    drop_d  = 1'b0;
                end else begin
                    if (cx_q == XMAX) begin
                        cx_d = '0;
                        cy_d = cy_q + 6'd1;
                    end else begin
                        cx_d = cx_q + 6'd1;
                    end
                    wr_d = '{x: cx_d, y: cy_d, char: '0};
                    we_d = 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ARB;
            last_q  <= IW'(NREQ - 1);
            cx_q    <= '0;
            cy_q    <= '0;
            wr_q    <= '0;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            wr_q    <= wr_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
        end
    end

    assign req_ready = reset_n ? ready_c : '0;
    assign x         = wr_q.x;
    assign y         = wr_q.y;
    assign char      = wr_q.char;
    assign we        = we_q;
    assign busy      = (state_q == ST_CLEAR);
    assign drop_err  = drop_q;

endmodule
